wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the 3-stage core. It sits between the execute stage and the register file write port.
- Holds the X->WB pipeline register and extracts and sign-extends load data from synchronous data memory.
- Selects the writeback source and drives rd_addr, wdata and RegWEn into the register file.
- The same signals are the execute-stage bypass source. Also maintains the retired-instruction counter (instret).

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RADDR_W, 5, register address width.
- CNT_W, 64, instret counter width.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- x_valid  in  1  execute stage holds a valid instruction this cycle.
- x_alu_result  in  XLEN  ALU result; the effective address for loads.
- x_pc  in  XLEN  PC of the instruction in X.
- x_rd_addr  in  RADDR_W  destination register.
- x_RegWEn  in  1  instruction writes rd.
- x_WBSel  in  2  writeback source: 0 mem, 1 alu, 2 pc+4, 3 treated as alu.
- x_funct3  in  3  load size and sign: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu.
- dmem_rdata  in  XLEN  synchronous DMEM read word. Address is presented in X; data is valid in WB.
- wb_rd_addr  out  RADDR_W  to RegFile rd_addr and the bypass compare.
- wb_wdata  out  XLEN  to RegFile wdata and the bypass data.
- wb_RegWEn  out  1  to RegFile RegWEn and the bypass enable.
- wb_load_fault  out  1  misaligned or reserved-size load in WB.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Pipeline register
  - Each posedge with reset=0, captures all x_* fields.
  - wb_valid_q <= x_valid. There is no stall input; upstream inserts bubbles by deasserting x_valid.
  - Instruction latency is 1 cycle: captured at edge N, visible in WB during cycle N..N+1, written into RegFile at edge N+1.
- Reset
  - wb_valid_q=0, all captured fields=0, instret=0.
  - Outputs are therefore wb_rd_addr=0, wb_wdata=0, wb_RegWEn=0, wb_load_fault=0.
  - Reset mid-operation: the instruction in WB is dropped. No write, no instret increment.
- Source mux (combinational from the WB register and dmem_rdata)
  - WBSel=0: load data.
  - WBSel=1 or 3: alu_q.
  - WBSel=2: pc_q+4, modulo 2^32; 0xFFFFFFFC+4 wraps to 0.
- Load extraction
  - off = alu_q[1:0].
  - Byte: dmem_rdata[8*off+7 : 8*off].
  - Half: dmem_rdata[16*off[1]+15 : 16*off[1]].
  - Sign-extend for funct3 0/1; zero-extend for 4/5. lw takes the whole word.
- Load fault (only when WBSel=0)
  - Fault if lh/lhu with off[0]=1, lw with off!=0, or funct3 in {3,6,7}.
  - On fault: wb_load_fault=1, wb_RegWEn=0, instret not incremented.
- wb_RegWEn = wb_valid_q & RegWEn_q & (rd_q!=0) & ~fault. x0 is never presented as a write or bypass hit.
- Bubble: wb_wdata and wb_rd_addr may hold stale values, but wb_RegWEn=0 and wb_load_fault=0.
- instret
  - Increments by 1 at posedge when wb_valid_q & ~fault, including instructions with RegWEn=0 (stores, branches).
  - Wraps 2^64-1 -> 0.
- No multicycle state. Back-to-back valid instructions retire one per cycle.

Decomposition:
- Shared package core_pkg holds:
  - WBSel encodings: WB_MEM=0, WB_ALU=1, WB_PC4=2.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - XLEN.
- One natural sub-module: load_align. It is purely combinational (rdata, off, funct3 -> data, fault) and is reused by any future load path.

Test Plan:
- Reset then x_valid=1, WBSel=1, alu=0x1234_5678, rd=5, RegWEn=1.
  - Next cycle: wb_RegWEn=1, rd=5, wdata=0x12345678.
  - After the following edge: instret=1.
- lb off=3, dmem_rdata=0x80FF_0000.
  - wdata=0xFFFFFF80.
  - Same access as lbu: wdata=0x00000080.
  - lhu off=2: wdata=0x000080FF.
- lw alu=0x1002 and lh alu=0x1001.
  - wb_load_fault=1, wb_RegWEn=0, instret unchanged.
  - lh alu=0x1002: no fault.
- jal-style WBSel=2, pc=0xFFFF_FFFC.
  - wdata=0x00000000.
  - rd=0 with RegWEn=1: wb_RegWEn=0 but instret increments.
- Alternating x_valid 1,0,1.
  - wb_RegWEn follows 1,0,1.
  - instret +2.
  - Assert reset while a valid instruction is in WB: no write, instret=0, outputs zero next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared definitions for the 3-stage core: datapath widths, writeback source
//   encodings, load funct3 codes and small extension helpers used by the load
//   path.
// -----------------------------------------------------------------------------
package core_pkg;

  // Datapath width. Only 32 is supported by the load path.
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 64;

  // Writeback source select. Encoding 3 is unused by the decoder and is
  // treated as an ALU writeback so a stray value can never select garbage.
  typedef enum logic [1:0] {
    WB_MEM     = 2'd0,
    WB_ALU     = 2'd1,
    WB_PC4     = 2'd2,
    WB_ALU_ALT = 2'd3
  } wb_sel_e;

  // Load size/sign encodings (funct3 of the load opcode).
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  function automatic logic [XLEN-1:0] sext8(input logic [7:0] b);
    return {{(XLEN-8){b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] zext8(input logic [7:0] b);
    return {{(XLEN-8){1'b0}}, b};
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] h);
    return {{(XLEN-16){h[15]}}, h};
  endfunction

  function automatic logic [XLEN-1:0] zext16(input logic [15:0] h);
    return {{(XLEN-16){1'b0}}, h};
  endfunction

endpackage : core_pkg

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
//   Purely combinational load-data extraction. Picks the addressed byte or
//   halfword out of a naturally aligned memory word, sign- or zero-extends it
//   according to funct3, and flags misaligned or reserved-size accesses.
//
// Ports
//   rdata_i   in  XLEN  word returned by data memory
//   off_i     in  2     byte offset within the word (address[1:0])
//   funct3_i  in  3     load size/sign encoding
//   data_o    out XLEN  extracted, extended load value
//   fault_o   out 1     access is misaligned or uses a reserved funct3
// -----------------------------------------------------------------------------
module load_align
  import core_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o,
  output logic            fault_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte lane = 8*off; halfword lane is chosen by off[1] only. A halfword
  // access with off[0]=1 faults below, so its data is never consumed.
  assign byte_sel = rdata_i[{off_i, 3'b000} +: 8];
  assign half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case, so no path through it leaves a value held and a latch inferred.
    data_o  = '0;
    fault_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = sext8(byte_sel);
      F3_LBU: data_o = zext8(byte_sel);
      F3_LH: begin
        data_o  = sext16(half_sel);
        fault_o = off_i[0];
      end
      F3_LHU: begin
        data_o  = zext16(half_sel);
        fault_o = off_i[0];
      end
      F3_LW: begin
        data_o  = rdata_i;
        fault_o = (off_i != 2'b00);
      end
      // funct3 3, 6 and 7 are reserved load sizes.
      default: fault_o = 1'b1;
    endcase
  end

endmodule : load_align

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
//   Writeback stage of the 3-stage core. Holds the X->WB pipeline register,
//   extracts load data from the synchronous DMEM read word, selects the
//   writeback source and drives the register file write port. The same
//   rd/wdata/RegWEn triple is the execute-stage bypass source. Also keeps
//   the retired-instruction counter.
//
// Ports
//   clk           in  1        core clock, all state updates on posedge
//   reset         in  1        synchronous, active-high reset
//   x_valid       in  1        X holds a valid instruction
//   x_alu_result  in  XLEN     ALU result / load effective address
//   x_pc          in  XLEN     PC of the instruction in X
//   x_rd_addr     in  RADDR_W  destination register
//   x_RegWEn      in  1        instruction writes rd
//   x_WBSel       in  2        writeback source (0 mem, 1 alu, 2 pc+4, 3 alu)
//   x_funct3      in  3        load size/sign
//   dmem_rdata    in  XLEN     DMEM read word for the instruction now in WB
//   wb_rd_addr    out RADDR_W  RegFile rd_addr / bypass compare
//   wb_wdata      out XLEN     RegFile wdata / bypass data
//   wb_RegWEn     out 1        RegFile write enable / bypass enable
//   wb_load_fault out 1        misaligned or reserved-size load in WB
//   instret       out CNT_W    retired-instruction count
// -----------------------------------------------------------------------------
module wb_stage
  import core_pkg::wb_sel_e;
  import core_pkg::WB_MEM;
  import core_pkg::WB_ALU;
  import core_pkg::WB_PC4;
  import core_pkg::WB_ALU_ALT;
#(
  parameter int XLEN    = core_pkg::XLEN,  // only 32 is supported
  parameter int RADDR_W = core_pkg::RADDR_W,
  parameter int CNT_W   = core_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x_valid,
  input  logic [XLEN-1:0]    x_alu_result,
  input  logic [XLEN-1:0]    x_pc,
  input  logic [RADDR_W-1:0] x_rd_addr,
  input  logic               x_RegWEn,
  input  logic [1:0]         x_WBSel,
  input  logic [2:0]         x_funct3,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic [RADDR_W-1:0] wb_rd_addr,
  output logic [XLEN-1:0]    wb_wdata,
  output logic               wb_RegWEn,
  output logic               wb_load_fault,
  output logic [CNT_W-1:0]   instret
);

  // ---------------------------------------------------------------------------
  // X->WB pipeline register
  // ---------------------------------------------------------------------------
  logic               wb_valid_q;
  logic [XLEN-1:0]    alu_q;
  logic [XLEN-1:0]    pc_q;
  logic [RADDR_W-1:0] rd_q;
  logic               regwen_q;
  wb_sel_e            wbsel_q;
  logic [2:0]         funct3_q;

  // There is no stall: every edge either captures the next instruction or a
  // bubble (x_valid=0). Fields are captured even for bubbles; only wb_valid_q
  // qualifies them.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      wb_valid_q <= 1'b0;
      alu_q      <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      regwen_q   <= 1'b0;
      wbsel_q    <= WB_MEM;
      funct3_q   <= 3'd0;
    end else begin
      wb_valid_q <= x_valid;
      alu_q      <= x_alu_result;
      pc_q       <= x_pc;
      rd_q       <= x_rd_addr;
      regwen_q   <= x_RegWEn;
      wbsel_q    <= wb_sel_e'(x_WBSel);
      funct3_q   <= x_funct3;
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction. The effective address was presented to DMEM in X, so the
  // matching word arrives on dmem_rdata while the instruction sits in WB.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] load_data;
  logic            align_fault;

  load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .off_i    (alu_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (load_data),
    .fault_o  (align_fault)
  );

  // funct3 is only meaningful for loads; non-load sources never fault.
  logic load_fault;
  logic retire;

  assign load_fault = wb_valid_q & (wbsel_q == WB_MEM) & align_fault;
  assign retire     = wb_valid_q & ~load_fault;

  // ---------------------------------------------------------------------------
  // Writeback source mux
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] wdata;

  always_comb begin
    wdata = alu_q;
    unique case (wbsel_q)
      WB_MEM:     wdata = load_data;
      WB_ALU:     wdata = alu_q;
      WB_PC4:     wdata = pc_q + XLEN'(4);  // wraps modulo 2^XLEN
      WB_ALU_ALT: wdata = alu_q;
    endcase
  end

  // x0 is hardwired: suppressing the enable here also keeps the bypass
  // network from ever matching a write to x0.
  assign wb_rd_addr    = rd_q;
  assign wb_wdata      = wdata;
  assign wb_RegWEn     = wb_valid_q & regwen_q & (rd_q != '0) & ~load_fault;
  assign wb_load_fault = load_fault;

  // ---------------------------------------------------------------------------
  // Retired-instruction counter. Counts every non-faulting valid instruction,
  // including ones that do not write rd (stores, branches). Wraps naturally.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;

  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
//   Directed bench for wb_stage. A small word-addressed memory behind a
//   registered read port stands in for synchronous DMEM. A behavioural model
//   tracks the instruction in WB and the retire count; a negedge process
//   compares DUT outputs to it every cycle, and literal expectations at the
//   directed points pin the model itself.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        x_valid;
  logic [31:0] x_alu_result;
  logic [31:0] x_pc;
  logic [4:0]  x_rd_addr;
  logic        x_RegWEn;
  logic [1:0]  x_WBSel;
  logic [2:0]  x_funct3;
  logic [31:0] dmem_rdata;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_wdata;
  logic        wb_RegWEn;
  logic        wb_load_fault;
  logic [63:0] instret;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk           (clk),
    .reset         (reset),
    .x_valid       (x_valid),
    .x_alu_result  (x_alu_result),
    .x_pc          (x_pc),
    .x_rd_addr     (x_rd_addr),
    .x_RegWEn      (x_RegWEn),
    .x_WBSel       (x_WBSel),
    .x_funct3      (x_funct3),
    .dmem_rdata    (dmem_rdata),
    .wb_rd_addr    (wb_rd_addr),
    .wb_wdata      (wb_wdata),
    .wb_RegWEn     (wb_RegWEn),
    .wb_load_fault (wb_load_fault),
    .instret       (instret)
  );

  // Synchronous DMEM: address presented in X, word valid during WB.
  logic [31:0] mem [0:15];
  always @(posedge clk) dmem_rdata <= mem[x_alu_result[5:2]];

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit          m_valid;
  bit          m_we;
  logic [31:0] m_alu;
  logic [31:0] m_pc;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel;
  logic [2:0]  m_f3;
  logic [63:0] m_instret;

  function automatic bit load_bad(input logic [31:0] addr, input logic [2:0] f3);
    int off = int'(addr % 4);
    if (f3 == 3 || f3 >= 6) return 1'b1;
    if ((f3 == 1 || f3 == 5) && (off % 2 == 1)) return 1'b1;
    if (f3 == 2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [2:0] f3);
    int off = int'(addr % 4);
    logic [31:0] b = (word >> (8 * off)) % 256;
    logic [31:0] h = (word >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd2:    return word;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_faulted();
    return m_valid && (m_sel == 2'd0) && load_bad(m_alu, m_f3);
  endfunction

  function automatic logic [31:0] m_wdata();
    case (m_sel)
      2'd0:    return load_val(mem[(m_alu / 4) % 16], m_alu, m_f3);
      2'd2:    return m_pc + 32'd4;
      default: return m_alu;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid   <= 1'b0;
      m_we      <= 1'b0;
      m_alu     <= '0;
      m_pc      <= '0;
      m_rd      <= '0;
      m_sel     <= '0;
      m_f3      <= '0;
      m_instret <= '0;
    end else begin
      if (m_valid && !m_faulted()) m_instret <= m_instret + 64'd1;
      m_valid <= x_valid;
      m_we    <= x_RegWEn;
      m_alu   <= x_alu_result;
      m_pc    <= x_pc;
      m_rd    <= x_rd_addr;
      m_sel   <= x_WBSel;
      m_f3    <= x_funct3;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("model_regwen", 64'(wb_RegWEn),
            64'(m_valid && m_we && (m_rd != 0) && !m_faulted()));
      check("model_fault", 64'(wb_load_fault), 64'(m_faulted()));
      check("model_instret", instret, m_instret);
      if (m_valid) check("model_rd", 64'(wb_rd_addr), 64'(m_rd));
      if (m_valid && !m_faulted()) check("model_wdata", 64'(wb_wdata), 64'(m_wdata()));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Presents one X-stage instruction; returns #1 after the edge that captured
  // it, i.e. with that instruction visible in WB.
  task automatic issue(input bit v, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [4:0] rd, input bit we,
                       input logic [2:0] f3);
    x_valid      = v;
    x_WBSel      = sel;
    x_alu_result = alu;
    x_pc         = pc;
    x_rd_addr    = rd;
    x_RegWEn     = we;
    x_funct3     = f3;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    issue(1'b0, 2'd1, 32'h0, 32'h0, 5'd0, 1'b0, 3'd0);
  endtask

  logic [63:0] base;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'h80FF_0000;
    mem[2] = 32'h89AB_CDEF;

    reset = 1'b1;
    x_valid = 1'b0; x_alu_result = '0; x_pc = '0; x_rd_addr = '0;
    x_RegWEn = 1'b0; x_WBSel = '0; x_funct3 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checking = 1'b1;

    check("reset_rd", 64'(wb_rd_addr), 64'h0);
    check("reset_wdata", 64'(wb_wdata), 64'h0);
    check("reset_regwen", 64'(wb_RegWEn), 64'h0);
    check("reset_fault", 64'(wb_load_fault), 64'h0);
    check("reset_instret", instret, 64'h0);

    // ALU writeback, one-cycle latency, instret after the following edge.
    issue(1'b1, 2'd1, 32'h1234_5678, 32'h100, 5'd5, 1'b1, 3'd0);
    check("alu_regwen", 64'(wb_RegWEn), 64'h1);
    check("alu_rd", 64'(wb_rd_addr), 64'd5);
    check("alu_wdata", 64'(wb_wdata), 64'h1234_5678);
    bubble();
    check("alu_instret", instret, 64'd1);

    // Byte/half extraction from 0x80FF0000.
    issue(1'b1, 2'd0, 32'h7, 32'h0, 5'd6, 1'b1, 3'd0);
    check("lb_off3", 64'(wb_wdata), 64'hFFFF_FF80);
    issue(1'b1, 2'd0, 32'h7, 32'h0, 5'd6, 1'b1, 3'd4);
    check("lbu_off3", 64'(wb_wdata), 64'h0000_0080);
    issue(1'b1, 2'd0, 32'h6, 32'h0, 5'd6, 1'b1, 3'd5);
    check("lhu_off2", 64'(wb_wdata), 64'h0000_80FF);

    // Misaligned loads fault, suppress the write and do not retire.
    issue(1'b1, 2'd0, 32'h1002, 32'h0, 5'd7, 1'b1, 3'd2);
    check("lw_mis_fault", 64'(wb_load_fault), 64'h1);
    check("lw_mis_regwen", 64'(wb_RegWEn), 64'h0);
    base = instret;
    issue(1'b1, 2'd0, 32'h1001, 32'h0, 5'd7, 1'b1, 3'd1);
    check("lh_mis_fault", 64'(wb_load_fault), 64'h1);
    check("lw_mis_instret", instret, base);
    issue(1'b1, 2'd0, 32'h1002, 32'h0, 5'd7, 1'b1, 3'd1);
    check("lh_ok_fault", 64'(wb_load_fault), 64'h0);
    check("lh_ok_regwen", 64'(wb_RegWEn), 64'h1);
    check("lh_mis_instret", instret, base);

    // pc+4 wrap, then an x0 write that still retires.
    issue(1'b1, 2'd2, 32'h0, 32'hFFFF_FFFC, 5'd1, 1'b1, 3'd0);
    check("pc4_wrap", 64'(wb_wdata), 64'h0);
    check("lh_ok_instret", instret, base + 64'd1);
    issue(1'b1, 2'd1, 32'h5, 32'h0, 5'd0, 1'b1, 3'd0);
    check("x0_regwen", 64'(wb_RegWEn), 64'h0);
    base = instret;
    bubble();
    check("x0_instret", instret, base + 64'd1);

    // Alternating valid 1,0,1.
    issue(1'b1, 2'd3, 32'hA, 32'h0, 5'd3, 1'b1, 3'd0);
    check("alt1_regwen", 64'(wb_RegWEn), 64'h1);
    check("sel3_wdata", 64'(wb_wdata), 64'hA);
    base = instret;
    issue(1'b0, 2'd1, 32'hB, 32'h0, 5'd3, 1'b1, 3'd0);
    check("alt0_regwen", 64'(wb_RegWEn), 64'h0);
    check("alt0_fault", 64'(wb_load_fault), 64'h0);
    issue(1'b1, 2'd1, 32'hC, 32'h0, 5'd3, 1'b1, 3'd0);
    check("alt2_regwen", 64'(wb_RegWEn), 64'h1);
    bubble();
    check("alt_instret", instret, base + 64'd2);

    // Sweep every funct3 at every offset over 0x89ABCDEF; the model checks.
    for (int f = 0; f < 8; f++) begin
      for (int o = 0; o < 4; o++) begin
        issue(1'b1, 2'd0, 32'(8 + o), 32'h0, 5'(f + 1), 1'b1, 3'(f));
      end
    end
    issue(1'b1, 2'd0, 32'h9, 32'h0, 5'd2, 1'b1, 3'd1);
    check("lh_off1_fault", 64'(wb_load_fault), 64'h1);
    issue(1'b1, 2'd0, 32'hA, 32'h0, 5'd2, 1'b1, 3'd1);
    check("lh_off2_wdata", 64'(wb_wdata), 64'hFFFF_89AB);
    issue(1'b1, 2'd0, 32'h9, 32'h0, 5'd2, 1'b1, 3'd0);
    check("lb_off1_wdata", 64'(wb_wdata), 64'hFFFF_FFCD);
    issue(1'b1, 2'd0, 32'h8, 32'h0, 5'd2, 1'b1, 3'd6);
    check("f3_6_fault", 64'(wb_load_fault), 64'h1);

    // Reset with a valid write in WB drops it.
    issue(1'b1, 2'd1, 32'h40, 32'h0, 5'd9, 1'b1, 3'd0);
    check("pre_reset_regwen", 64'(wb_RegWEn), 64'h1);
    reset = 1'b1;
    x_valid = 1'b0;
    x_alu_result = 32'h0;
    @(posedge clk);
    #1;
    check("mid_reset_regwen", 64'(wb_RegWEn), 64'h0);
    check("mid_reset_instret", instret, 64'h0);
    check("mid_reset_rd", 64'(wb_rd_addr), 64'h0);
    check("mid_reset_wdata", 64'(wb_wdata), 64'h0);
    reset = 1'b0;
    bubble();
    check("post_reset_instret", instret, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_wb_stage
